// File: rtl/box_overlay.sv
// box_overlay: draws up to N_BOX hollow rectangles over a video stream.
// Box coordinates are written into a shadow table at any time. They are
// copied to the active table in the cycle after each vsync rising edge,
// so a frame never shows a partly updated set of boxes.
// Pipeline: stage 1 registers the box match, stage 2 registers the
// output pixel. Every output is delayed by exactly two clocks.
// Optional build macro BOX_OVERLAY_BLEND_EN: active pixels become a 50%
// blend of input and box colour. Without it, the box colour replaces them.
module box_overlay #(
  parameter int N_BOX    = 4,
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int H_BORDER = 2,
  parameter int V_BORDER = 2,
  localparam int XW      = $clog2(H_ACT),
  localparam int YW      = $clog2(V_ACT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic [7:0]    i_r,
  input  logic [7:0]    i_g,
  input  logic [7:0]    i_b,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [3:0]    cfg_idx,
  input  logic          cfg_en,
  input  logic [XW-1:0] cfg_sx,
  input  logic [XW-1:0] cfg_ex,
  input  logic [YW-1:0] cfg_sy,
  input  logic [YW-1:0] cfg_ey,
  input  logic [23:0]   cfg_color,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b
);

  // Border thicknesses at the widened width, so the inner-rectangle
  // arithmetic cannot wrap.
  localparam logic [XW:0] HB_X = (XW+1)'(H_BORDER);
  localparam logic [YW:0] VB_Y = (YW+1)'(V_BORDER);

  typedef struct packed {
    logic          en;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [23:0]   color;
  } box_t;

  box_t shadow_tbl [N_BOX];
  box_t active_tbl [N_BOX];

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          de_d;
  logic          vs_d;
  logic          commit;
  logic          vs_rise;
  logic          de_fall;
  logic          cfg_wr;

  logic [N_BOX-1:0] box_on;
  logic             hit;
  logic [23:0]      hit_color;

  logic        s1_hit;
  logic [23:0] s1_color;
  logic [23:0] s1_pix;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_de;
  logic [23:0] sel_pix;

  assign vs_rise   = i_vsync & ~vs_d;
  assign de_fall   = ~i_de & de_d;
  // The commit cycle is the only cycle in which a write could race the
  // shadow-to-active copy, so writes are refused only there.
  assign cfg_ready = ~commit;
  assign cfg_wr    = cfg_valid & cfg_ready;

  // Edge detectors, commit strobe and the raster x/y position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d   <= 1'b0;
      vs_d   <= 1'b0;
      commit <= 1'b0;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else begin
      de_d   <= i_de;
      vs_d   <= i_vsync;
      commit <= vs_rise;
      if (i_de) begin
        x_cnt <= x_cnt + XW'(1);
      end else if (de_fall) begin
        x_cnt <= '0;
      end
      if (vs_rise) begin
        y_cnt <= '0;
      end else if (de_fall) begin
        y_cnt <= y_cnt + YW'(1);
      end
    end
  end

  // Shadow table. An index at or above N_BOX matches no entry, so the write is accepted and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_BOX; k++) begin
        shadow_tbl[k] <= '0;
      end
    end else if (cfg_wr) begin
      for (int unsigned k = 0; k < N_BOX; k++) begin
        if ({1'b0, cfg_idx} == 5'(k)) begin
          shadow_tbl[k].en    <= cfg_en;
          shadow_tbl[k].sx    <= cfg_sx;
          shadow_tbl[k].sy    <= cfg_sy;
          shadow_tbl[k].ex    <= cfg_ex;
          shadow_tbl[k].ey    <= cfg_ey;
          shadow_tbl[k].color <= cfg_color;
        end
      end
    end
  end

  // Active table: whole-table copy in the commit cycle. A write made in the vsync-rise cycle is already in the shadow table here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_BOX; k++) begin
        active_tbl[k] <= '0;
      end
    end else if (commit) begin
      for (int unsigned k = 0; k < N_BOX; k++) begin
        active_tbl[k] <= shadow_tbl[k];
      end
    end
  end

  // Per-box border test: inside the outer rectangle and outside the inner one.
  always_comb begin
    box_on = '0;
    for (int unsigned k = 0; k < N_BOX; k++) begin
      box_on[k] = active_tbl[k].en
        && (x_cnt >= active_tbl[k].sx) && (x_cnt <= active_tbl[k].ex)
        && (y_cnt >= active_tbl[k].sy) && (y_cnt <= active_tbl[k].ey)
        && !( ({1'b0, x_cnt} >= ({1'b0, active_tbl[k].sx} + HB_X))
           && ({1'b0, active_tbl[k].ex} >= HB_X)
           && ({1'b0, x_cnt} <= ({1'b0, active_tbl[k].ex} - HB_X))
           && ({1'b0, y_cnt} >= ({1'b0, active_tbl[k].sy} + VB_Y))
           && ({1'b0, active_tbl[k].ey} >= VB_Y)
           && ({1'b0, y_cnt} <= ({1'b0, active_tbl[k].ey} - VB_Y)) );
    end
  end

  // Overlap priority: a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit       = 1'b0;
    hit_color = '0;
    for (int unsigned k = 0; k < N_BOX; k++) begin
      if (box_on[k]) begin
        hit       = 1'b1;
        hit_color = active_tbl[k].color;
      end
    end
  end

  // Stage 1: capture match result with the pixel and timing it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit   <= 1'b0;
      s1_color <= '0;
      s1_pix   <= '0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_de    <= 1'b0;
    end else begin
      s1_hit   <= hit & i_de;
      s1_color <= hit_color;
      s1_pix   <= {i_r, i_g, i_b};
      s1_hs    <= i_hsync;
      s1_vs    <= i_vsync;
      s1_de    <= i_de;
    end
  end

  // Colour select: box colour (or blend) on a hit, otherwise pass-through.
  always_comb begin
    sel_pix = s1_pix;
    if (s1_hit) begin
`ifdef BOX_OVERLAY_BLEND_EN
      sel_pix[23:16] = 8'(({1'b0, s1_pix[23:16]} + {1'b0, s1_color[23:16]}) >> 1);
      sel_pix[15:8]  = 8'(({1'b0, s1_pix[15:8]}  + {1'b0, s1_color[15:8]})  >> 1);
      sel_pix[7:0]   = 8'(({1'b0, s1_pix[7:0]}   + {1'b0, s1_color[7:0]})   >> 1);
`else
      sel_pix = s1_color;
`endif
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_r     <= sel_pix[23:16];
      o_g     <= sel_pix[15:8];
      o_b     <= sel_pix[7:0];
      o_hsync <= s1_hs;
      o_vsync <= s1_vs;
      o_de    <= s1_de;
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Self-checking bench for box_overlay. A frame-level reference model
// predicts every output pixel two clocks after its input. A table of
// hand-computed pixel expectations covers the fixed scenarios.
module tb_box_overlay;

  localparam int NB     = 4;
  localparam int HA     = 64;
  localparam int VA     = 64;
  localparam int HBD    = 2;
  localparam int VBD    = 2;
  localparam int XW     = $clog2(HA);
  localparam int YW     = $clog2(VA);
  localparam int W      = 40;
  localparam int LINES  = 36;
  localparam int HBLANK = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_hsync, i_vsync, i_de;
  logic [7:0]    i_r, i_g, i_b;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_idx;
  logic          cfg_en;
  logic [XW-1:0] cfg_sx, cfg_ex;
  logic [YW-1:0] cfg_sy, cfg_ey;
  logic [23:0]   cfg_color;
  logic          o_hsync, o_vsync, o_de;
  logic [7:0]    o_r, o_g, o_b;

  box_overlay #(
    .N_BOX(NB), .H_ACT(HA), .V_ACT(VA), .H_BORDER(HBD), .V_BORDER(VBD)
  ) dut (
    .clk(clk), .rst(rst),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_sx(cfg_sx), .cfg_ex(cfg_ex),
    .cfg_sy(cfg_sy), .cfg_ey(cfg_ey), .cfg_color(cfg_color),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    int          sx, sy, ex, ey;
    logic [23:0] col;
  } mbox_t;

  typedef struct {
    bit          valid;
    logic        hs, vs, de;
    logic [23:0] pix;
    int          x, y;
  } pend_t;

  typedef struct {
    int          grp;
    int          x, y;
    logic [23:0] rep;
    logic [23:0] bl;
  } vec_t;

  mbox_t       shadow [NB];
  mbox_t       active [NB];
  pend_t       pend;
  int          mx, my;
  bit          prev_vs, prev_de, commit_next, last_acc;
  int          ready_lows;
  logic [23:0] cap [LINES][W];
  vec_t        vt [40];
  int          nv;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mix(input logic [23:0] in, input logic [23:0] c);
`ifdef BOX_OVERLAY_BLEND_EN
    int r, g, b;
    r = (int'(in[23:16]) + int'(c[23:16])) / 2;
    g = (int'(in[15:8])  + int'(c[15:8]))  / 2;
    b = (int'(in[7:0])   + int'(c[7:0]))   / 2;
    return {r[7:0], g[7:0], b[7:0]};
`else
    return (in & 24'h0) | c;
`endif
  endfunction

  // Reference: last enabled box whose frame (outer minus inner) holds (x,y).
  function automatic logic [23:0] ref_pix(input int x, input int y, input logic [23:0] in);
    int win;
    bit outer, inner;
    win = -1;
    for (int k = 0; k < NB; k++) begin
      outer = active[k].en && x >= active[k].sx && x <= active[k].ex
                           && y >= active[k].sy && y <= active[k].ey;
      inner = x >= active[k].sx + HBD && x <= active[k].ex - HBD
           && y >= active[k].sy + VBD && y <= active[k].ey - VBD;
      if (outer && !inner) win = k;
    end
    if (win < 0) return in;
    return mix(in, active[win].col);
  endfunction

  task automatic add_vec(input int g, input int x, input int y, input logic [23:0] rep, input logic [23:0] bl);
    vt[nv].grp = g; vt[nv].x = x; vt[nv].y = y; vt[nv].rep = rep; vt[nv].bl = bl;
    nv++;
  endtask

  task automatic check_group(input int g);
    logic [23:0] e;
    for (int i = 0; i < nv; i++) begin
      if (vt[i].grp == g) begin
`ifdef BOX_OVERLAY_BLEND_EN
        e = vt[i].bl;
`else
        e = vt[i].rep;
`endif
        check($sformatf("table g%0d pixel(%0d,%0d)", g, vt[i].x, vt[i].y),
              64'(cap[vt[i].y][vt[i].x]), 64'(e));
      end
    end
  endtask

  // One pixel clock: drive at the falling edge, advance the model at the
  // rising edge, then check the outputs for the input of the previous call.
  task automatic step(input logic hs_i, input logic vs_i, input logic de_i, input logic [23:0] pix);
    pend_t cur;
    bit    rdy;
    i_hsync = hs_i; i_vsync = vs_i; i_de = de_i;
    {i_r, i_g, i_b} = pix;
    rdy = !commit_next;
    check("cfg_ready", 64'(cfg_ready), 64'(rdy));
    if (cfg_ready === 1'b0) ready_lows++;
    cur.valid = 1'b1;
    cur.hs = hs_i; cur.vs = vs_i; cur.de = de_i;
    cur.x = mx; cur.y = my;
    cur.pix = de_i ? ref_pix(mx, my, pix) : pix;
    @(posedge clk);
    last_acc = cfg_valid && rdy;
    if (last_acc && int'(cfg_idx) < NB) begin
      shadow[int'(cfg_idx)].en  = cfg_en;
      shadow[int'(cfg_idx)].sx  = int'(cfg_sx);
      shadow[int'(cfg_idx)].sy  = int'(cfg_sy);
      shadow[int'(cfg_idx)].ex  = int'(cfg_ex);
      shadow[int'(cfg_idx)].ey  = int'(cfg_ey);
      shadow[int'(cfg_idx)].col = cfg_color;
    end
    if (commit_next) for (int k = 0; k < NB; k++) active[k] = shadow[k];
    commit_next = vs_i && !prev_vs;
    if (vs_i && !prev_vs) my = 0;
    else if (!de_i && prev_de) my++;
    if (de_i) mx++;
    else if (prev_de) mx = 0;
    prev_vs = vs_i; prev_de = de_i;
    @(negedge clk);
    if (pend.valid) begin
      check($sformatf("pixel de=%0b x=%0d y=%0d", pend.de, pend.x, pend.y),
            64'({o_r, o_g, o_b}), 64'(pend.pix));
      check("timing", 64'({o_hsync, o_vsync, o_de}), 64'({pend.hs, pend.vs, pend.de}));
      if (pend.de && pend.x < W && pend.y < LINES) cap[pend.y][pend.x] = {o_r, o_g, o_b};
    end
    pend = cur;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset pixel", 64'({o_r, o_g, o_b}), 64'd0);
    check("reset timing", 64'({o_hsync, o_vsync, o_de}), 64'd0);
    check("reset cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NB; k++) begin
      shadow[k] = '{1'b0, 0, 0, 0, 0, 24'h0};
      active[k] = '{1'b0, 0, 0, 0, 0, 24'h0};
    end
    mx = 0; my = 0;
    prev_vs = 1'b0; prev_de = 1'b0; commit_next = 1'b0;
    pend.valid = 1'b0;
  endtask

  task automatic set_cfg(input int idx, input bit en, input int sx, input int sy,
                         input int ex, input int ey, input logic [23:0] col);
    cfg_idx = idx[3:0]; cfg_en = en;
    cfg_sx = sx[XW-1:0]; cfg_sy = sy[YW-1:0];
    cfg_ex = ex[XW-1:0]; cfg_ey = ey[YW-1:0];
    cfg_color = col;
  endtask

  task automatic cfg_write(input int idx, input bit en, input int sx, input int sy,
                           input int ex, input int ey, input logic [23:0] col);
    set_cfg(idx, en, sx, sy, ex, ey, col);
    cfg_valid = 1'b1;
    step(1'b0, 1'b0, 1'b0, 24'($urandom));
    cfg_valid = 1'b0;
    check("cfg write accepted", 64'(last_acc), 64'd1);
  endtask

  // One frame: vsync pulse, blanking, LINES active lines with hblank.
  // Optional write during a line blank or in the vsync-rise cycle, and an optional reset at (rst_line, rst_px).
  task automatic frame(input bit rnd, input logic [23:0] col, input int wr_line,
                       input bit wr_vs, input int rst_line, input int rst_px);
    ready_lows = 0;
    for (int s = 0; s < 3; s++) begin
      if (s == 0 && wr_vs) cfg_valid = 1'b1;
      step(1'b0, 1'b1, 1'b0, 24'($urandom));
      cfg_valid = 1'b0;
    end
    for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 1'b0, 24'($urandom));
    for (int l = 0; l < LINES; l++) begin
      for (int p = 0; p < W; p++) begin
        if (l == rst_line && p == rst_px) do_reset();
        step(1'b0, 1'b0, 1'b1, rnd ? 24'($urandom) : col);
      end
      for (int s = 0; s < HBLANK; s++) begin
        if (s == 0 && l == wr_line) cfg_valid = 1'b1;
        step(s >= 1 && s <= 2, 1'b0, 1'b0, 24'($urandom));
        cfg_valid = 1'b0;
      end
    end
    check("cfg_ready low cycles per frame", 64'(ready_lows), 64'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    i_r = '0; i_g = '0; i_b = '0; cfg_valid = 1'b0;
    set_cfg(0, 1'b0, 0, 0, 0, 0, 24'h0);
    nv = 0;
    // Box (10,10)-(20,20) red over grey.
    add_vec(0, 10, 15, 24'hFF0000, 24'hBF4040);
    add_vec(0, 15, 15, 24'h808080, 24'h808080);
    add_vec(0, 21, 15, 24'h808080, 24'h808080);
    add_vec(0, 11, 11, 24'hFF0000, 24'hBF4040);
    add_vec(0, 12, 12, 24'h808080, 24'h808080);
    add_vec(0, 20, 20, 24'hFF0000, 24'hBF4040);
    add_vec(0, 10,  9, 24'h808080, 24'h808080);
    add_vec(0, 18, 18, 24'h808080, 24'h808080);
    add_vec(0, 19, 18, 24'hFF0000, 24'hBF4040);
    // Same box red over blue input.
    add_vec(1, 10, 15, 24'hFF0000, 24'h7F007F);
    add_vec(1, 15, 15, 24'h0000FF, 24'h0000FF);
    // Tiny box with empty inner rectangle; inverted box never drawn.
    add_vec(2,  5,  5, 24'hFF0000, 24'hBF4040);
    add_vec(2,  6,  5, 24'hFF0000, 24'hBF4040);
    add_vec(2,  5,  6, 24'hFF0000, 24'hBF4040);
    add_vec(2,  6,  6, 24'hFF0000, 24'hBF4040);
    add_vec(2,  7,  5, 24'h808080, 24'h808080);
    add_vec(2,  4,  6, 24'h808080, 24'h808080);
    add_vec(2,  5,  7, 24'h808080, 24'h808080);
    add_vec(2,  9,  6, 24'h808080, 24'h808080);
    add_vec(2,  3,  6, 24'h808080, 24'h808080);
    add_vec(2,  6,  8, 24'h808080, 24'h808080);
    // Overlap: box 0 green, box 2 blue.
    add_vec(3, 30, 30, 24'h0000FF, 24'h4040BF);
    add_vec(3, 31, 30, 24'h00FF00, 24'h40BF40);
    add_vec(3, 25, 30, 24'h0000FF, 24'h4040BF);
    add_vec(3, 35, 25, 24'h808080, 24'h808080);
    add_vec(3, 39, 25, 24'h00FF00, 24'h40BF40);
    // Mid-frame write not yet visible.
    add_vec(4,  0, 25, 24'h808080, 24'h808080);
    add_vec(4,  1, 20, 24'h808080, 24'h808080);
    // After commit, including the write made in the vsync-rise cycle.
    add_vec(5,  0, 25, 24'hFFFF00, 24'hBFBF40);
    add_vec(5, 10,  2, 24'h00FFFF, 24'h40BFBF);
    add_vec(5, 12,  2, 24'h808080, 24'h808080);
    add_vec(5, 30, 30, 24'h0000FF, 24'h4040BF);
    // After reset: all boxes gone.
    add_vec(6,  0, 25, 24'h808080, 24'h808080);
    add_vec(6, 10,  2, 24'h808080, 24'h808080);
    add_vec(6, 30, 30, 24'h808080, 24'h808080);
    add_vec(6, 10, 15, 24'h808080, 24'h808080);

    @(negedge clk);
    do_reset();
    frame(1'b1, 24'h0, -1, 1'b0, -1, -1);

    cfg_write(0, 1'b1, 10, 10, 20, 20, 24'hFF0000);
    frame(1'b0, 24'h808080, -1, 1'b0, -1, -1); check_group(0);
    frame(1'b0, 24'h0000FF, -1, 1'b0, -1, -1); check_group(1);

    cfg_write(0, 1'b1, 5, 5, 6, 6, 24'hFF0000);
    cfg_write(1, 1'b1, 9, 5, 3, 8, 24'h00FF00);
    frame(1'b0, 24'h808080, -1, 1'b0, -1, -1); check_group(2);

    cfg_write(0, 1'b1, 30, 20, 39, 30, 24'h00FF00);
    cfg_write(1, 1'b0, 0, 0, 0, 0, 24'h0);
    cfg_write(2, 1'b1, 20, 30, 30, 35, 24'h0000FF);
    frame(1'b0, 24'h808080, -1, 1'b0, -1, -1); check_group(3);
    frame(1'b1, 24'h0, -1, 1'b0, -1, -1);

    set_cfg(1, 1'b1, 0, 20, 5, 30, 24'hFFFF00);
    frame(1'b0, 24'h808080, 10, 1'b0, -1, -1); check_group(4);
    set_cfg(3, 1'b1, 10, 0, 15, 5, 24'h00FFFF);
    frame(1'b0, 24'h808080, -1, 1'b1, -1, -1); check_group(5);

    frame(1'b0, 24'h808080, -1, 1'b0, 12, 15);
    frame(1'b0, 24'h808080, -1, 1'b0, -1, -1); check_group(6);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NB; k++) begin
        cfg_write(k, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, W - 1)), int'($urandom_range(0, LINES - 1)),
                  int'($urandom_range(0, W - 1)), int'($urandom_range(0, LINES - 1)),
                  24'($urandom));
      end
      cfg_write(int'($urandom_range(NB, 15)), 1'b1, 0, 0, W - 1, LINES - 1, 24'($urandom));
      frame(1'b1, 24'h0, -1, 1'b0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
